// File: rtl/serial_pattern_gen_if.sv
// Control/serial-line bundle of the framed bit-pattern transmitter.
// master = control logic driving requests, slave = the generator.
interface serial_pattern_gen_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic [CNT_W-1:0] repeat_cnt;
    logic             abort;
    logic             dout;
    logic             dout_valid;
    logic             frame_start;
    logic             frame_end;
    logic [CNT_W-1:0] frame_idx;
    logic             busy;
    logic             done;
    logic             aborted;

    modport master (
        output start, repeat_cnt, abort,
        input  dout, dout_valid, frame_start, frame_end, frame_idx,
               busy, done, aborted
    );

    modport slave (
        input  start, repeat_cnt, abort,
        output dout, dout_valid, frame_start, frame_end, frame_idx,
               busy, done, aborted
    );
endinterface

// File: rtl/serial_pattern_gen.sv
// Framed serial pattern transmitter: sends PATTERN MSB first, repeat_cnt times,
// with GAP idle cycles between frames; all outputs come straight from flops.
module serial_pattern_gen #(
    parameter int                 PAT_LEN = 6,
    parameter logic [PAT_LEN-1:0] PATTERN = 6'b101001,
    parameter int                 CNT_W   = 8,
    parameter int                 GAP     = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_pattern_gen_if.slave  bus
);

    localparam int BIT_W = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [BIT_W-1:0] BIT_TOP  = BIT_W'(PAT_LEN - 1);
    localparam logic [BIT_W-1:0] BIT_ZERO = {BIT_W{1'b0}};
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
    localparam logic [GAP_W-1:0] GAP_ZERO = {GAP_W{1'b0}};
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
    localparam logic [GAP_W-1:0] GAP_TOP  = (GAP > 0) ? GAP_W'(GAP - 1) : GAP_ZERO;
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] frame_idx_q, frame_idx_d;
    logic             dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             frame_start_q, frame_start_d;
    logic             frame_end_q, frame_end_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             aborted_q, aborted_d;

    function automatic logic pattern_bit(input logic [BIT_W-1:0] idx);
        return PATTERN[idx];
    endfunction

    // Next-state and next-output decode; outputs describe the cycle after the edge.
    always_comb begin
        state_d       = state_q;
        bit_d         = bit_q;
        gap_d         = gap_q;
        rem_d         = rem_q;
        frame_idx_d   = frame_idx_q;
        dout_d        = 1'b0;
        dout_valid_d  = 1'b0;
        frame_start_d = 1'b0;
        frame_end_d   = 1'b0;
        busy_d        = 1'b0;
        done_d        = 1'b0;
        aborted_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                frame_idx_d = CNT_ZERO;
                if (bus.start && (bus.repeat_cnt != CNT_ZERO)) begin
                    state_d       = ST_SEND;
                    bit_d         = BIT_TOP;
                    gap_d         = GAP_ZERO;
                    rem_d         = bus.repeat_cnt - CNT_ONE;
                    dout_d        = pattern_bit(BIT_TOP);
                    dout_valid_d  = 1'b1;
                    frame_start_d = 1'b1;
                    busy_d        = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_SEND: begin
                if (bus.abort) begin
                    // abort wins over frame completion in the same cycle
                    state_d     = ST_IDLE;
                    bit_d       = BIT_ZERO;
                    gap_d       = GAP_ZERO;
                    rem_d       = CNT_ZERO;
                    frame_idx_d = CNT_ZERO;
                    aborted_d   = 1'b1;
                end else if (bit_q != BIT_ZERO) begin
                    bit_d        = bit_q - BIT_ONE;
                    dout_d       = pattern_bit(bit_q - BIT_ONE);
                    dout_valid_d = 1'b1;
                    frame_end_d  = (bit_q == BIT_ONE);
                    busy_d       = 1'b1;
                end else if (rem_q != CNT_ZERO) begin
                    rem_d  = rem_q - CNT_ONE;
                    busy_d = 1'b1;
                    if (GAP > 0) begin
                        state_d = ST_GAP;
                        gap_d   = GAP_TOP;
                    end else begin
                        state_d       = ST_SEND;
                        bit_d         = BIT_TOP;
                        dout_d        = pattern_bit(BIT_TOP);
                        dout_valid_d  = 1'b1;
                        frame_start_d = 1'b1;
                        frame_idx_d   = frame_idx_q + CNT_ONE;
                    end
                end else begin
                    state_d     = ST_DONE;
                    frame_idx_d = CNT_ZERO;
                    done_d      = 1'b1;
                end
            end

            ST_GAP: begin
                if (bus.abort) begin
                    state_d     = ST_IDLE;
                    bit_d       = BIT_ZERO;
                    gap_d       = GAP_ZERO;
                    rem_d       = CNT_ZERO;
                    frame_idx_d = CNT_ZERO;
                    aborted_d   = 1'b1;
                end else if (gap_q != GAP_ZERO) begin
                    gap_d  = gap_q - GAP_ONE;
                    busy_d = 1'b1;
                end else begin
                    state_d       = ST_SEND;
                    bit_d         = BIT_TOP;
                    dout_d        = pattern_bit(BIT_TOP);
                    dout_valid_d  = 1'b1;
                    frame_start_d = 1'b1;
                    frame_idx_d   = frame_idx_q + CNT_ONE;
                    busy_d        = 1'b1;
                end
            end

            ST_DONE: begin
                // start and abort are both ignored while the done pulse is out
                state_d     = ST_IDLE;
                frame_idx_d = CNT_ZERO;
            end

            default: begin
                state_d     = ST_IDLE;
                bit_d       = BIT_ZERO;
                gap_d       = GAP_ZERO;
                rem_d       = CNT_ZERO;
                frame_idx_d = CNT_ZERO;
            end
        endcase
    end

    // State, counters and output flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            bit_q         <= BIT_ZERO;
            gap_q         <= GAP_ZERO;
            rem_q         <= CNT_ZERO;
            frame_idx_q   <= CNT_ZERO;
            dout_q        <= 1'b0;
            dout_valid_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            aborted_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_q         <= bit_d;
            gap_q         <= gap_d;
            rem_q         <= rem_d;
            frame_idx_q   <= frame_idx_d;
            dout_q        <= dout_d;
            dout_valid_q  <= dout_valid_d;
            frame_start_q <= frame_start_d;
            frame_end_q   <= frame_end_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            aborted_q     <= aborted_d;
        end
    end

    assign bus.dout        = dout_q;
    assign bus.dout_valid  = dout_valid_q;
    assign bus.frame_start = frame_start_q;
    assign bus.frame_end   = frame_end_q;
    assign bus.frame_idx   = frame_idx_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.aborted     = aborted_q;

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Scoreboard bench for serial_pattern_gen: one instance with GAP=0 (plus a
// loopback pattern detector) and one with GAP=2.
module tb_serial_pattern_gen;

    logic clk;
    logic rst;
    int   cyc;
    int   total;
    int   bad;

    logic [5:0] pat = 6'b101001;

    typedef struct packed {
        logic       d;
        logic       fs;
        logic       fe;
        logic [7:0] idx;
    } beat_t;

    beat_t q0[$];
    beat_t q2[$];

    int done_n[2];
    int abrt_n[2];
    int busy_n[2];
    int gapc_n[2];
    int done_cyc[2];
    int fs_cyc[2];
    int det_n;
    logic [5:0] sh;

    serial_pattern_gen_if #(.CNT_W(8)) bus0 ();
    serial_pattern_gen_if #(.CNT_W(8)) bus2 ();

    serial_pattern_gen #(.PAT_LEN(6), .PATTERN(6'b101001), .CNT_W(8), .GAP(0)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    serial_pattern_gen #(.PAT_LEN(6), .PATTERN(6'b101001), .CNT_W(8), .GAP(2)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // loopback detector fed by the gated serial line of the GAP=0 instance
    always @(posedge clk or posedge rst) begin
        if (rst) sh <= 6'd0;
        else     sh <= {sh[4:0], bus0.dout & bus0.dout_valid};
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic mon_step(input int w, input logic d, input logic v, input logic fs,
                            input logic fe, input logic [7:0] idx, input logic busy,
                            input logic done, input logic ab);
        beat_t e;
        if (busy) busy_n[w]++;
        if (busy && !v) gapc_n[w]++;
        if (done) begin done_n[w]++; done_cyc[w] = cyc; end
        if (ab) abrt_n[w]++;
        if (fs) fs_cyc[w] = cyc;
        if (v) begin
            if ((w == 0 && q0.size() == 0) || (w == 2 && q2.size() == 0) || (w == 1 && q2.size() == 0)) begin
                chk($sformatf("unexpected_beat%0d", w), {d, fs, fe, idx}, 11'd0);
            end else begin
                e = (w == 0) ? q0.pop_front() : q2.pop_front();
                chk($sformatf("beat%0d", w), {d, fs, fe, idx}, e);
            end
        end else begin
            chk($sformatf("idle_line%0d", w), {d, fs, fe}, 3'd0);
        end
        if (!busy) chk($sformatf("idle_idx%0d", w), idx, 8'd0);
    endtask

    // scoreboard monitor: consumes expected beats as the DUTs present them
    always @(negedge clk) begin
        mon_step(0, bus0.dout, bus0.dout_valid, bus0.frame_start, bus0.frame_end,
                 bus0.frame_idx, bus0.busy, bus0.done, bus0.aborted);
        mon_step(1, bus2.dout, bus2.dout_valid, bus2.frame_start, bus2.frame_end,
                 bus2.frame_idx, bus2.busy, bus2.done, bus2.aborted);
        if (sh == pat) det_n++;
    end

    task automatic push_frames(input int which, input int n);
        beat_t e;
        for (int f = 0; f < n; f++) begin
            for (int b = 5; b >= 0; b--) begin
                e.d   = pat[b];
                e.fs  = (b == 5);
                e.fe  = (b == 0);
                e.idx = 8'(f);
                if (which == 0) q0.push_back(e);
                else            q2.push_back(e);
            end
        end
    endtask

    task automatic go(input int which, input logic [7:0] n, input bit push, output int s);
        @(negedge clk);
        if (which == 0) begin bus0.start = 1'b1; bus0.repeat_cnt = n; end
        else            begin bus2.start = 1'b1; bus2.repeat_cnt = n; end
        s = cyc + 1;
        if (push) push_frames(which, int'(n));
        @(negedge clk);
        bus0.start = 1'b0;
        bus2.start = 1'b0;
    endtask

    function automatic logic busy_of(input int which);
        return (which == 0) ? bus0.busy : bus2.busy;
    endfunction

    task automatic wait_idle(input int which, input int budget);
        int k;
        k = 0;
        while (busy_of(which) && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("idle_within_budget", (k < budget), 1'b1);
        repeat (3) @(negedge clk);
    endtask

    int s, s2, dn, ab, bn, gn, dt;

    initial begin
        #50000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0; bad = 0; det_n = 0;
        for (int i = 0; i < 2; i++) begin
            done_n[i] = 0; abrt_n[i] = 0; busy_n[i] = 0; gapc_n[i] = 0;
            done_cyc[i] = 0; fs_cyc[i] = 0;
        end
        bus0.start = 1'b0; bus0.repeat_cnt = 8'd0; bus0.abort = 1'b0;
        bus2.start = 1'b0; bus2.repeat_cnt = 8'd0; bus2.abort = 1'b0;
        rst = 1'b1;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_outputs0", {bus0.dout, bus0.dout_valid, bus0.frame_start, bus0.frame_end,
                             bus0.frame_idx, bus0.busy, bus0.done, bus0.aborted}, 15'd0);
        chk("rst_outputs2", {bus2.dout, bus2.dout_valid, bus2.frame_start, bus2.frame_end,
                             bus2.frame_idx, bus2.busy, bus2.done, bus2.aborted}, 15'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // T1: single frame, 1-cycle latency, done on cycle 7
        dn = done_n[0]; bn = busy_n[0];
        go(0, 8'd1, 1'b1, s);
        chk("t1_first_valid", {bus0.dout_valid, bus0.frame_start, bus0.busy}, 3'b111);
        wait_idle(0, 40);
        chk("t1_fs_cycle", fs_cyc[0] - s, 0);
        chk("t1_done_latency", done_cyc[0] - s, 6);
        chk("t1_done_count", done_n[0] - dn, 1);
        chk("t1_busy_cycles", busy_n[0] - bn, 6);
        chk("t1_queue_empty", q0.size(), 0);

        // T2: GAP=2, three frames
        dn = done_n[1]; bn = busy_n[1]; gn = gapc_n[1];
        go(2, 8'd3, 1'b1, s);
        wait_idle(2, 60);
        chk("t2_busy_cycles", busy_n[1] - bn, 22);
        chk("t2_gap_cycles", gapc_n[1] - gn, 4);
        chk("t2_done_count", done_n[1] - dn, 1);
        chk("t2_done_latency", done_cyc[1] - s, 22);
        chk("t2_queue_empty", q2.size(), 0);

        // T3: zero-count start ignored; start during a frame not queued
        dn = done_n[0]; bn = busy_n[0];
        go(0, 8'd0, 1'b1, s);
        repeat (8) @(negedge clk);
        chk("t3_zero_busy", busy_n[0] - bn, 0);
        chk("t3_zero_done", done_n[0] - dn, 0);
        go(0, 8'd1, 1'b1, s);
        while (cyc < s + 2) @(negedge clk);
        bus0.start = 1'b1; bus0.repeat_cnt = 8'd5;
        @(negedge clk);
        bus0.start = 1'b0;
        wait_idle(0, 40);
        chk("t3_done_count", done_n[0] - dn, 1);
        chk("t3_busy_cycles", busy_n[0] - bn, 6);
        chk("t3_queue_empty", q0.size(), 0);

        // T4: abort on bit 3 of frame 1, then immediate restart
        dn = done_n[0]; ab = abrt_n[0];
        go(0, 8'd3, 1'b0, s);
        push_frames(0, 1);
        q0.push_back('{d: 1'b1, fs: 1'b1, fe: 1'b0, idx: 8'd1});
        q0.push_back('{d: 1'b0, fs: 1'b0, fe: 1'b0, idx: 8'd1});
        q0.push_back('{d: 1'b1, fs: 1'b0, fe: 1'b0, idx: 8'd1});
        while (cyc < s + 8) @(negedge clk);
        bus0.abort = 1'b1;
        @(negedge clk);
        bus0.abort = 1'b0;
        chk("t4_after_abort", {bus0.dout_valid, bus0.busy, bus0.aborted, bus0.done,
                               bus0.frame_idx}, {4'b0010, 8'd0});
        bus0.start = 1'b1; bus0.repeat_cnt = 8'd1;
        push_frames(0, 1);
        @(negedge clk);
        bus0.start = 1'b0;
        chk("t4_restart", {bus0.busy, bus0.frame_start, bus0.aborted}, 3'b110);
        wait_idle(0, 40);
        chk("t4_abort_count", abrt_n[0] - ab, 1);
        chk("t4_done_count", done_n[0] - dn, 1);
        chk("t4_queue_empty", q0.size(), 0);

        // T5: asynchronous reset mid-frame
        dn = done_n[0]; ab = abrt_n[0];
        go(0, 8'd2, 1'b1, s);
        while (cyc < s + 3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t5_async_clear", {bus0.dout, bus0.dout_valid, bus0.frame_start, bus0.frame_end,
                               bus0.frame_idx, bus0.busy, bus0.done, bus0.aborted}, 15'd0);
        q0.delete();
        @(negedge clk);
        rst = 1'b0;
        bn = busy_n[0];
        repeat (10) @(negedge clk);
        chk("t5_no_done", done_n[0] - dn, 0);
        chk("t5_no_aborted", abrt_n[0] - ab, 0);
        chk("t5_stays_idle", busy_n[0] - bn, 0);

        // T6: loopback into detector, four back-to-back frames
        dt = det_n; dn = done_n[0];
        go(0, 8'd4, 1'b1, s);
        wait_idle(0, 60);
        repeat (4) @(negedge clk);
        chk("t6_detections", det_n - dt, 4);
        chk("t6_done_count", done_n[0] - dn, 1);
        chk("t6_done_latency", done_cyc[0] - s, 24);
        chk("t6_queue_empty", q0.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
